// File: rtl/display_pkg.sv
// Shared segment glyphs, serializer state encoding and frame sizing helper
// for the 7-segment display serializer.
package display_pkg;

   // Active-high segments: bit0=a ... bit6=g, bit7=dp (dp is OR-ed in separately).
   localparam logic [7:0] SEG_0     = 8'h3F;
   localparam logic [7:0] SEG_1     = 8'h06;
   localparam logic [7:0] SEG_2     = 8'h5B;
   localparam logic [7:0] SEG_3     = 8'h4F;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'h6D;
   localparam logic [7:0] SEG_6     = 8'h7D;
   localparam logic [7:0] SEG_7     = 8'h07;
   localparam logic [7:0] SEG_8     = 8'h7F;
   localparam logic [7:0] SEG_9     = 8'h6F;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      LATCH,
      GAP
   } ser_state_t;

   function automatic int frame_bits(input int num_digits);
      return 8 * num_digits;
   endfunction

endpackage

// File: rtl/display_seg_decode.sv
// One BCD digit to 8-bit segment word; non-decimal codes give an empty glyph
// but still carry the decimal point.
module display_seg_decode
   import display_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       dp,
   output logic [7:0] seg
);

   logic [7:0] glyph;

   // NOTE: assigning a default before the case keeps combinational logic latch-free.
   always_comb begin
      glyph = SEG_BLANK;
      case (bcd)
         4'd0:    glyph = SEG_0;
         4'd1:    glyph = SEG_1;
         4'd2:    glyph = SEG_2;
         4'd3:    glyph = SEG_3;
         4'd4:    glyph = SEG_4;
         4'd5:    glyph = SEG_5;
         4'd6:    glyph = SEG_6;
         4'd7:    glyph = SEG_7;
         4'd8:    glyph = SEG_8;
         4'd9:    glyph = SEG_9;
         default: glyph = SEG_BLANK;
      endcase
   end

   assign seg = glyph | {dp, 7'b0};

endmodule

// File: rtl/display_serializer.sv
// Serial driver for an N-digit 7-segment shift-register board with periodic refresh.
// Define DISPLAY_SER_BLANK_EN to suppress leading zero digits.
module display_serializer
   import display_pkg::*;
#(
   parameter int NUM_DIGITS    = 4,
   parameter int SEND_INTERVAL = 1600,
   parameter bit MSB_FIRST     = 1'b0
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [4*NUM_DIGITS-1:0] bcd_in,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic                    bcd_valid,
   output logic                    bcd_ready,
   output logic                    ser_data,
   output logic                    sending_data,
   output logic                    ser_latch
);

   localparam int FRAME_BITS = frame_bits(NUM_DIGITS);
   localparam int TW         = $clog2(SEND_INTERVAL);
   // tcnt holds the frame tick just driven; the loading IDLE tick is tick 0.
   localparam logic [TW-1:0] LAST_BIT_PREV = TW'(FRAME_BITS - 2);
   localparam logic [TW-1:0] GAP_END_PREV  = TW'(SEND_INTERVAL - 2);

   if (SEND_INTERVAL < FRAME_BITS + 2) begin : g_bad_interval
      $error("display_serializer: SEND_INTERVAL must be at least FRAME_BITS+2");
   end

   logic [4*NUM_DIGITS-1:0] hold_bcd;
   logic [NUM_DIGITS-1:0]   hold_dp;
   logic                    pending;
   logic                    has_data;
   logic [NUM_DIGITS-1:0]   blank;
   logic [FRAME_BITS-1:0]   frame_word;
   logic [FRAME_BITS-1:0]   send_word;
   logic [FRAME_BITS-1:0]   last_frame;
   logic [FRAME_BITS-1:0]   shreg;
   logic [TW-1:0]           tcnt;
   ser_state_t              state;

   assign bcd_ready = ~pending;

`ifdef DISPLAY_SER_BLANK_EN
   // Walk down from the most significant digit; digit 0 always shows.
   always_comb begin
      logic lead;
      lead  = 1'b1;
      blank = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         lead     = lead & (hold_bcd[4*i +: 4] == 4'd0);
         blank[i] = lead;
      end
   end
`else
   assign blank = '0;
`endif

   // A blanked digit is forced to code F, which decodes empty but keeps its dp.
   for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
      display_seg_decode u_dec (
         .bcd (blank[i] ? 4'hF : hold_bcd[4*i +: 4]),
         .dp  (hold_dp[i]),
         .seg (frame_word[8*i +: 8])
      );
   end

   // The shift register always emits bit 0 first, so the word is stored in send order.
   if (MSB_FIRST) begin : g_msb_first
      for (genvar b = 0; b < FRAME_BITS; b++) begin : g_rev
         assign send_word[b] = frame_word[FRAME_BITS-1-b];
      end
   end else begin : g_lsb_first
      assign send_word = frame_word;
   end

   // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         tcnt         <= '0;
         pending      <= 1'b0;
         has_data     <= 1'b0;
         hold_bcd     <= '0;
         hold_dp      <= '0;
         last_frame   <= '0;
         shreg        <= '0;
         ser_data     <= 1'b0;
         sending_data <= 1'b0;
         ser_latch    <= 1'b0;
      end else begin
         if (bcd_valid && !pending) begin
            hold_bcd <= bcd_in;
            hold_dp  <= dp_in;
            pending  <= 1'b1;
         end

         if (enable) begin
            case (state)
               IDLE: begin
                  ser_latch <= 1'b0;
                  tcnt      <= '0;
                  if (pending) begin
                     last_frame   <= send_word;
                     shreg        <= send_word >> 1;
                     ser_data     <= send_word[0];
                     sending_data <= 1'b1;
                     pending      <= 1'b0;
                     has_data     <= 1'b1;
                     state        <= SHIFT;
                  end else if (has_data) begin
                     shreg        <= last_frame >> 1;
                     ser_data     <= last_frame[0];
                     sending_data <= 1'b1;
                     state        <= SHIFT;
                  end else begin
                     ser_data     <= 1'b0;
                     sending_data <= 1'b0;
                  end
               end
               SHIFT: begin
                  ser_data <= shreg[0];
                  shreg    <= shreg >> 1;
                  tcnt     <= tcnt + 1'b1;
                  if (tcnt == LAST_BIT_PREV) state <= LATCH;
               end
               LATCH: begin
                  ser_data     <= 1'b0;
                  sending_data <= 1'b0;
                  ser_latch    <= 1'b1;
                  tcnt         <= tcnt + 1'b1;
                  state        <= GAP;
               end
               GAP: begin
                  ser_data  <= 1'b0;
                  ser_latch <= 1'b0;
                  tcnt      <= tcnt + 1'b1;
                  if (tcnt == GAP_END_PREV) state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/display_serializer.md
# display_serializer

Parametrised serial driver for multi-digit 7-segment displays. Accepts a packed BCD word plus decimal points over a valid/ready handshake, decodes each digit to an 8-bit segment word, and shifts the frame out one bit per `enable` tick, followed by a latch strobe. The last frame is re-sent every `SEND_INTERVAL` ticks. It sits between the measurement/datapath logic and the external shift-register display board.

## Interface
- `NUM_DIGITS`, 4: digits per frame; `FRAME_BITS = 8*NUM_DIGITS`.
- `SEND_INTERVAL`, 1600: frame period in ticks; must be `>= FRAME_BITS+2`, enforced by an elaboration-time check.
- `MSB_FIRST`, 0: 0 sends frame bit 0 first; 1 sends bit `FRAME_BITS-1` first.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-low reset.
- `enable`  input  1  bit-rate tick, one-cycle strobe; FSM advances only on tick cycles.
- `bcd_in`  input  4*NUM_DIGITS  packed BCD; digit 0 is in bits [3:0].
- `dp_in`  input  NUM_DIGITS  decimal point per digit.
- `bcd_valid`  input  1  word offered.
- `bcd_ready`  output  1  holding register free.
- `ser_data`  output  1  serial segment data.
- `sending_data`  output  1  high while frame bits are driven.
- `ser_latch`  output  1  one-tick latch strobe after the last bit.

## Operation
- Segment encoding (active-high): bit0=a … bit6=g, bit7=dp. Digits 0-9 map to 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex). BCD values A-F map to 00 (dp still applied). Digit i occupies frame bits [8i+7:8i].
- Handshake: `bcd_ready = !pending`. On a `bcd_valid & bcd_ready` cycle, `bcd_in`/`dp_in` are captured into the holding register and `pending` is set. Capture is independent of `enable`.
- The FSM has four states:
  - `IDLE`: on a tick, if `pending`, load the decoded holding word into the shift register, clear `pending`, set `has_data`, clear `tcnt`, go to `SHIFT`. Otherwise, if `has_data`, reload the last frame (refresh) and go to `SHIFT`. Otherwise stay.
  - `SHIFT`: each tick drives one bit and increments `tcnt`. After bit `FRAME_BITS-1`, go to `LATCH`.
  - `LATCH`: one tick with `ser_latch=1`, `ser_data=0`, then go to `GAP`.
  - `GAP`: `ser_data=0`. Count ticks until `tcnt == SEND_INTERVAL-1`, then go to `IDLE`.
- `tcnt` is `$clog2(SEND_INTERVAL)` bits wide and never wraps inside a frame.
- Data accepted mid-frame does not alter the current frame; it is sent in the next frame, starting at the next `IDLE` tick.
- Reset values: `ser_data=0`, `sending_data=0`, `ser_latch=0`, `bcd_ready=1`, state `IDLE`, `pending=0`, `has_data=0`.
- Asynchronous reset mid-frame abandons the frame immediately. No latch pulse is produced, and no frame is sent until a new word is accepted.

## Timing
- All outputs are registered and update on the `clk` edge of a tick cycle. They hold their value between ticks.
- Frame start: the first bit appears on the edge of the `IDLE` tick that loads the frame. `sending_data` rises on the same edge and stays high for exactly `FRAME_BITS` ticks.
- `ser_latch` is high for the single tick following the last bit.
- Frame period is exactly `SEND_INTERVAL` ticks, measured between consecutive first-bit edges (one extra `IDLE` tick is included in the count).
- Handshake latency: `bcd_ready` drops the cycle after acceptance. It rises the cycle after the loading tick.
- `enable` held low: the FSM freezes and outputs hold, but one word can still be accepted.

## Configuration
- `DISPLAY_SER_BLANK_EN` defined: leading-zero suppression. The most-significant consecutive digits equal to 0 emit 00 (plus dp if set). Digit 0 is never blanked.
- Macro undefined: every 0 digit emits 3F.

## Structure
- Shared package `display_pkg` holds:
  - the segment constants (SEG_0 … SEG_9, SEG_BLANK);
  - the FSM state enum (IDLE, SHIFT, LATCH, GAP);
  - the frame-width function.
- Sub-module `display_seg_decode`: combinational, 4-bit BCD plus dp in, 8-bit segment word out. Instantiated `NUM_DIGITS` times by a generate loop.

## Test plan
Unless stated otherwise: NUM_DIGITS=4, SEND_INTERVAL=40, `enable=1` every cycle.
- Frame content: accept `bcd_in=0x1234`, `dp_in=0`, MSB_FIRST=0. Expect first 8 bits 0,1,1,0,0,1,1,0 (66), then 4F, 5B, 06 LSB-first; `sending_data` high for 32 ticks; one `ser_latch` pulse at tick 32.
- Refresh: no further input. Expect an identical second frame starting exactly 40 ticks after the first bit; `ser_data=0` in the gap.
- Backpressure: offer 0x1111 mid-frame, then 0x2222 immediately after. Expect 0x1111 accepted with `bcd_ready` low; 0x2222 held off until the next frame load; next frame shows 06 ×4.
- Invalid/dp and bit order: `bcd_in=0x00A8`, `dp_in=0001`, MSB_FIRST=1. Expect digit 0 = FF and digit 1 = 00, with bit 31 sent first.
- Blanking: `bcd_in=0x0007`. With `DISPLAY_SER_BLANK_EN`, frame = 07,00,00,00 (digit 0 first). Without it, frame = 07,3F,3F,3F.
- Reset mid-frame: assert `reset` low at bit 10. Expect `ser_data`, `sending_data` and `ser_latch` at 0 immediately and `bcd_ready=1`; after release, no frame until a new word is accepted.
